alu_share_arbiter: RTL



---
 rtl/alu_arb_pkg.sv | 18 +
 rtl/ALU_64bit.sv | 40 ++++
 rtl/rr_grant.sv | 56 +++++
 rtl/alu_share_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the shared-ALU arbiter.
// Contents: datapath width, ALU op codes and the arbiter FSM state encoding.
package alu_arb_pkg;

   localparam int XLEN = 64;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/ALU_64bit.sv
// Combinational 64-bit integer ALU shared by all requesters.
// Ports:
//   a, b      operands
//   op        operation code (AND/OR/ADD/SUB; anything else yields 0)
//   result    operation result, wraps modulo 2^XLEN
//   zero      result == 0
//   overflow  signed overflow of ADD/SUB, 0 for all other codes
module ALU_64bit
   import alu_arb_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            overflow
);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (op)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_ADD: begin
            result   = a + b;
            // operands share a sign but the sum does not
            overflow = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
         end
         OP_SUB: begin
            // operands differ in sign and the difference flips away from a
            result   = a - b;
            overflow = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
         end
         default: result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/rr_grant.sv
// Grant selection for the shared ALU.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no pointer input); otherwise round robin starting at ptr.
// Ports:
//   req      request vector
//   ptr      round-robin search start (round-robin build only)
//   gnt      one-hot grant, zero when no request
//   gnt_idx  index of the granted requester
//   gnt_any  some requester was granted
module rr_grant #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
   input  logic [IDW-1:0]  ptr,
`endif
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            gnt_any
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      // scan downwards so the lowest requesting index is the last written
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) gnt_idx = IDW'(i);
      end
      gnt_any = |req;
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end
`else
   int             idx;
   logic [IDW-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx  = (int'(ptr) + k) % NREQ;
         cand = IDW'(idx);
         if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 64-bit ALU between NREQ requesters with a tagged response.
// Build option: ALU_ARB_FIXED_PRIO_EN -> fixed priority (requester 0 first),
// default -> round robin.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_ready       per-requester handshake (ready is one-hot or 0)
//   req_a/req_b/req_op        packed per-requester operands and op code
//   rsp_valid/rsp_ready       response handshake
//   rsp_id                    owning requester of the result
//   rsp_result/zero/overflow  registered ALU outputs
//
// state  | meaning
// S_IDLE | arbitrate; grant combinationally and latch operands
// S_EXEC | ALU works on latched operands; register the result
// S_RESP | hold response until rsp_ready
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter  int NREQ = 2,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*XLEN-1:0] req_a,
   input  logic [NREQ*XLEN-1:0] req_b,
   input  logic [NREQ*4-1:0]    req_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [XLEN-1:0]      rsp_result,
   output logic                 rsp_zero,
   output logic                 rsp_overflow
);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
   logic [3:0]        op_code_q, op_code_d;
   logic [IDW-1:0]    op_id_q, op_id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [XLEN-1:0]   rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_overflow_q, rsp_overflow_d;

   logic [NREQ-1:0]   gnt;
   logic [IDW-1:0]    gnt_idx;
   logic              gnt_any;
   logic [XLEN-1:0]   sel_a, sel_b;
   logic [3:0]        sel_op;
   logic [XLEN-1:0]   alu_result;
   logic              alu_zero, alu_overflow;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
`endif

   rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
      .req     (req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
      .ptr     (rr_ptr_q),
`endif
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   ALU_64bit u_alu (
      .a        (op_a_q),
      .b        (op_b_q),
      .op       (op_code_q),
      .result   (alu_result),
      .zero     (alu_zero),
      .overflow (alu_overflow)
   );

   // operand mux for the winning requester
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_a  = req_a[i*XLEN +: XLEN];
            sel_b  = req_b[i*XLEN +: XLEN];
            sel_op = req_op[i*4 +: 4];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      op_code_d      = op_code_q;
      op_id_d        = op_id_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_id_d       = rsp_id_q;
      rsp_result_d   = rsp_result_q;
      rsp_zero_d     = rsp_zero_q;
      rsp_overflow_d = rsp_overflow_q;
      req_ready      = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_d       = rr_ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (gnt_any) begin
               req_ready = gnt;
               op_a_d    = sel_a;
               op_b_d    = sel_b;
               op_code_d = sel_op;
               op_id_d   = gnt_idx;
               state_d   = S_EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
               rr_ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
`endif
            end
         end
         S_EXEC: begin
            rsp_valid_d    = 1'b1;
            rsp_id_d       = op_id_q;
            rsp_result_d   = alu_result;
            rsp_zero_d     = alu_zero;
            rsp_overflow_d = alu_overflow;
            state_d        = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         op_a_q         <= '0;
         op_b_q         <= '0;
         op_code_q      <= '0;
         op_id_q        <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_result_q   <= '0;
         rsp_zero_q     <= 1'b0;
         rsp_overflow_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         rr_ptr_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         op_code_q      <= op_code_d;
         op_id_q        <= op_id_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_result_q   <= rsp_result_d;
         rsp_zero_q     <= rsp_zero_d;
         rsp_overflow_q <= rsp_overflow_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
         rr_ptr_q       <= rr_ptr_d;
`endif
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_zero     = rsp_zero_q;
   assign rsp_overflow = rsp_overflow_q;

endmodule
